// File: rtl/bcd_digit_scanner_if.sv
// Digit-scanner bus: frame load input plus per-slot display outputs.
interface bcd_digit_scanner_if #(
  parameter int N_DIGITS = 4
);
  logic [4*N_DIGITS-1:0] digits_in;
  logic                  load;
  logic [3:0]            bcd_out;
  logic [N_DIGITS-1:0]   digit_en;
  logic                  blank;
  logic                  frame_done;

  modport master (
    output digits_in, load,
    input  bcd_out, digit_en, blank, frame_done
  );

  modport slave (
    input  digits_in, load,
    output bcd_out, digit_en, blank, frame_done
  );
endinterface

// File: rtl/bcd_digit_scanner.sv
// Time-multiplexed 7-segment scan controller with frame-synchronous digit updates.
// Optional leading-zero suppression is enabled by defining BCD_SCAN_LZ_BLANK_EN.
module bcd_digit_scanner #(
  parameter int N_DIGITS = 4,
  parameter int PRESCALE = 4,
  parameter int DEADTIME = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bcd_digit_scanner_if.slave   bus
);

  localparam int DW = 4 * N_DIGITS;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
  localparam logic [CW-1:0] DT       = CW'(DEADTIME);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] stg_q, stg_d;
  logic [DW-1:0] shd_q, shd_d;
  logic          pend_q, pend_d;
  logic          active_q;

  logic          cnt_last;
  logic          frame_end;
  logic [3:0]    cur_digit;
  logic          suppress;
  logic          blank_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      stg_q    <= '0;
      shd_q    <= '0;
      pend_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      stg_q    <= stg_d;
      shd_q    <= shd_d;
      pend_q   <= pend_d;
      active_q <= 1'b1;
    end
  end

  always_comb begin
    cnt_last  = (cnt_q == CNT_LAST);
    frame_end = cnt_last && (idx_q == IDX_LAST);
    cnt_d     = cnt_last ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    stg_d     = stg_q;
    shd_d     = shd_q;
    pend_d    = pend_q;
    if (cnt_last) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    if (bus.load) begin
      stg_d  = bus.digits_in;
      pend_d = 1'b1;
    end
    // A load landing on the boundary bypasses staging so it shows next frame.
    if (frame_end) begin
      if (bus.load) begin
        shd_d  = bus.digits_in;
        pend_d = 1'b0;
      end else if (pend_q) begin
        shd_d  = stg_q;
        pend_d = 1'b0;
      end
    end
  end

  assign cur_digit = shd_q[{idx_q, 2'b00} +: 4];

`ifdef BCD_SCAN_LZ_BLANK_EN
  logic [N_DIGITS-1:0] lz;

  // Digit i is a leading zero when it and every higher digit are zero; digit 0 never is.
  always_comb begin
    lz = '0;
    for (int i = 1; i < N_DIGITS; i++) begin
      lz[i] = ((shd_q >> (4 * i)) == '0);
    end
  end

  assign suppress = lz[idx_q];
`else
  assign suppress = 1'b0;
`endif

  assign blank_w = (cur_digit > 4'd9) || suppress;

  // active_q keeps enables off while reset is held, whatever DEADTIME is.
  always_comb begin
    bus.bcd_out    = cur_digit;
    bus.blank      = blank_w;
    bus.frame_done = frame_end;
    bus.digit_en   = '0;
    if (active_q && !blank_w && (cnt_q >= DT)) begin
      bus.digit_en = {{(N_DIGITS-1){1'b0}}, 1'b1} << idx_q;
    end
  end

endmodule
